// File: rtl/timer_alarm_scheduler.sv
// Multi-channel alarm controller on top of the 100 us free-running 16-bit timer.
// Channels are armed with a tick delay, scanned round-robin, and reported on a fire port.
module timer_alarm_scheduler #(
    parameter int NUM_ALARMS = 4,
    parameter int ID_W       = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           timer_count,
    output logic                  timer_read,
    output logic                  timer_reset,
    input  logic                  clear_timer,
    input  logic                  arm_valid,
    output logic                  arm_ready,
    input  logic [ID_W-1:0]       arm_id,
    input  logic [14:0]           arm_delay,
    input  logic                  cancel_valid,
    input  logic [ID_W-1:0]       cancel_id,
    output logic                  fire_valid,
    output logic [ID_W-1:0]       fire_id,
    input  logic                  fire_ready,
    output logic [NUM_ALARMS-1:0] armed,
    output logic [NUM_ALARMS-1:0] pending
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t          state;
    logic            phase;
    logic [15:0]     deadline [NUM_ALARMS];
    logic [ID_W-1:0] scan_idx;
    logic [ID_W-1:0] rr_ptr;

    logic                  arm_fire;
    logic                  enter_clear;
    logic                  scan_hit;
    logic [15:0]           scan_diff;
    logic [NUM_ALARMS-1:0] arm_mask;
    logic [NUM_ALARMS-1:0] cancel_mask;
    logic [NUM_ALARMS-1:0] expire_mask;
    logic [NUM_ALARMS-1:0] ack_mask;
    logic [NUM_ALARMS-1:0] pend_avail;
    logic [NUM_ALARMS-1:0] armed_nxt;
    logic [NUM_ALARMS-1:0] pending_nxt;
    logic [ID_W-1:0]       pick_id;
    logic                  pick_found;
    logic                  fire_cancelled;

    function automatic logic [ID_W-1:0] add_wrap(input logic [ID_W-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NUM_ALARMS) s = s - NUM_ALARMS;
        return ID_W'(s);
    endfunction

    // Control FSM: a two-cycle settle after reset and after every timer clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_INIT;
            phase       <= 1'b0;
            timer_read  <= 1'b0;
            timer_reset <= 1'b0;
            arm_ready   <= 1'b0;
        end else begin
            timer_read  <= 1'b1;
            timer_reset <= 1'b0;
            case (state)
                ST_INIT, ST_CLEAR: begin
                    if (phase) begin
                        state     <= ST_RUN;
                        phase     <= 1'b0;
                        arm_ready <= 1'b1;
                    end else begin
                        phase <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clear_timer) begin
                        state       <= ST_CLEAR;
                        phase       <= 1'b0;
                        timer_reset <= 1'b1;
                        arm_ready   <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_INIT;
                    phase     <= 1'b0;
                    arm_ready <= 1'b0;
                end
            endcase
        end
    end

    assign arm_fire    = arm_valid && arm_ready;
    assign enter_clear = (state == ST_RUN) && clear_timer;

    // Expired when the signed distance past the deadline is non-negative (wrap-safe).
    assign scan_diff = timer_count - deadline[scan_idx];
    assign scan_hit  = (state == ST_RUN) && armed[scan_idx] && !scan_diff[15];

    always_comb begin
        arm_mask    = '0;
        cancel_mask = '0;
        expire_mask = '0;
        ack_mask    = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            arm_mask[i]    = arm_fire && (arm_id == ID_W'(i));
            cancel_mask[i] = cancel_valid && (cancel_id == ID_W'(i));
            ack_mask[i]    = fire_valid && fire_ready && (fire_id == ID_W'(i));
            expire_mask[i] = scan_hit && (scan_idx == ID_W'(i)) && !arm_mask[i] && !cancel_mask[i];
        end
    end

    // Cancel beats arm, arm beats a same-cycle expiry of the same channel.
    assign armed_nxt      = enter_clear ? '0 : (((armed & ~expire_mask) | arm_mask) & ~cancel_mask);
    assign pending_nxt    = ((pending & ~ack_mask) | expire_mask) & ~cancel_mask;
    assign pend_avail     = pending & ~cancel_mask;
    assign fire_cancelled = cancel_valid && (cancel_id == fire_id);

    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = 0; k < NUM_ALARMS; k++) begin
            if (!pick_found && pend_avail[add_wrap(rr_ptr, k)]) begin
                pick_found = 1'b1;
                pick_id    = add_wrap(rr_ptr, k);
            end
        end
    end

    // Fire port: fire_id is held while fire_valid && !fire_ready; a transfer happens on
    // the edge where both are high, and fire_valid always drops for one cycle afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed      <= '0;
            pending    <= '0;
            fire_valid <= 1'b0;
            fire_id    <= '0;
            scan_idx   <= '0;
            rr_ptr     <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) deadline[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (arm_mask[i]) deadline[i] <= timer_count + {1'b0, arm_delay};
            end
            armed   <= armed_nxt;
            pending <= pending_nxt;
            if (state == ST_RUN) scan_idx <= add_wrap(scan_idx, 1);
            if (fire_valid) begin
                if (fire_ready) begin
                    fire_valid <= 1'b0;
                    rr_ptr     <= add_wrap(fire_id, 1);
                end else if (fire_cancelled) begin
                    fire_valid <= 1'b0;
                end
            end else if (pick_found) begin
                fire_valid <= 1'b1;
                fire_id    <= pick_id;
            end
        end
    end

endmodule

// File: tb/tb_timer_alarm_scheduler.sv
// Directed bench for timer_alarm_scheduler: expected fire ids are queued when alarms are
// set up and popped when the fire handshake completes.
`timescale 1ns/1ps
module tb_timer_alarm_scheduler;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [15:0]    timer_count;
    logic           timer_read;
    logic           timer_reset;
    logic           clear_timer;
    logic           arm_valid;
    logic           arm_ready;
    logic [IDW-1:0] arm_id;
    logic [14:0]    arm_delay;
    logic           cancel_valid;
    logic [IDW-1:0] cancel_id;
    logic           fire_valid;
    logic [IDW-1:0] fire_id;
    logic           fire_ready;
    logic [N-1:0]   armed;
    logic [N-1:0]   pending;

    int checks = 0;
    int fails  = 0;
    logic [IDW-1:0] exp_q[$];
    logic prev_hs = 1'b0;
    logic [15:0] base;
    logic [15:0] dly;

    timer_alarm_scheduler #(.NUM_ALARMS(N), .ID_W(IDW)) dut (
        .clk(clk), .reset(reset), .timer_count(timer_count), .timer_read(timer_read),
        .timer_reset(timer_reset), .clear_timer(clear_timer), .arm_valid(arm_valid),
        .arm_ready(arm_ready), .arm_id(arm_id), .arm_delay(arm_delay),
        .cancel_valid(cancel_valid), .cancel_id(cancel_id), .fire_valid(fire_valid),
        .fire_id(fire_id), .fire_ready(fire_ready), .armed(armed), .pending(pending)
    );

    always #40 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        if (prev_hs) check("bubble", 32'(fire_valid), 32'd0);
        if (fire_valid === 1'b1 && fire_ready === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_fire", 32'(fire_valid), 32'd0);
            else check("fire_id_order", 32'(fire_id), 32'(exp_q.pop_front()));
            prev_hs = 1'b1;
        end else begin
            prev_hs = 1'b0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            monitor();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic arm(input int id, input int d);
        arm_valid = 1'b1;
        arm_id    = IDW'(id);
        arm_delay = 15'(d);
        for (int i = 0; i < 10 && arm_ready !== 1'b1; i++) tick(1);
        check("arm_ready", 32'(arm_ready), 32'd1);
        tick(1);
        arm_valid = 1'b0;
    endtask

    task automatic cancel(input int id);
        cancel_valid = 1'b1;
        cancel_id    = IDW'(id);
        tick(1);
        cancel_valid = 1'b0;
    endtask

    task automatic wait_fire(input string tag, input int bound);
        for (int i = 0; i < bound && fire_valid !== 1'b1; i++) tick(1);
        check(tag, 32'(fire_valid), 32'd1);
    endtask

    task automatic drain(input string tag, input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) tick(1);
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1; timer_count = 16'd0; clear_timer = 1'b0;
        arm_valid = 1'b0; arm_id = '0; arm_delay = '0;
        cancel_valid = 1'b0; cancel_id = '0; fire_ready = 1'b0;
        tick(2);
        check("rst_timer_read", 32'(timer_read), 32'd0);
        check("rst_timer_reset", 32'(timer_reset), 32'd0);
        check("rst_arm_ready", 32'(arm_ready), 32'd0);
        check("rst_fire_valid", 32'(fire_valid), 32'd0);
        check("rst_fire_id", 32'(fire_id), 32'd0);
        check("rst_armed", 32'(armed), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        reset = 1'b0;
        tick(1);
        check("init_timer_read", 32'(timer_read), 32'd1);
        check("init_arm_ready", 32'(arm_ready), 32'd0);
        tick(1);
        check("run_arm_ready", 32'(arm_ready), 32'd1);

        // Basic arm and fire.
        timer_count = 16'd100;
        arm(1, 5);
        check("t1_armed", 32'(armed), 32'b0010);
        timer_count = 16'd104;
        tick(8);
        check("t1_early_fire", 32'(fire_valid), 32'd0);
        check("t1_early_pending", 32'(pending), 32'd0);
        exp_q.push_back(2'd1);
        timer_count = 16'd105;
        wait_fire("t1_fire_valid", 7);
        check("t1_fire_id", 32'(fire_id), 32'd1);
        check("t1_pending_set", 32'(pending), 32'b0010);
        check("t1_disarmed", 32'(armed), 32'd0);
        fire_ready = 1'b1;
        tick(1);
        fire_ready = 1'b0;
        check("t1_pending_clr", 32'(pending), 32'd0);
        check("t1_fire_drop", 32'(fire_valid), 32'd0);
        check("t1_consumed", 32'(exp_q.size()), 32'd0);

        // Deadline across the 16-bit wrap.
        timer_count = 16'd65534;
        arm(0, 4);
        for (int c = 0; c < 3; c++) begin
            timer_count = (c == 0) ? 16'd65535 : 16'(c - 1);
            tick(6);
            check("t2_no_early_fire", 32'(fire_valid), 32'd0);
        end
        exp_q.push_back(2'd0);
        timer_count = 16'd2;
        wait_fire("t2_fire_valid", 7);
        check("t2_fire_id", 32'(fire_id), 32'd0);
        fire_ready = 1'b1;
        drain("t2_drain", 4);
        fire_ready = 1'b0;

        // Move the round-robin pointer back to 0 by firing channel 3.
        exp_q.push_back(2'd3);
        arm(3, 0);
        wait_fire("t3_pre_fire", 7);
        fire_ready = 1'b1;
        drain("t3_pre_drain", 4);
        fire_ready = 1'b0;

        // Hold channel 1 on the port while 0,2,3 expire together, then cancel it.
        arm(1, 0);
        wait_fire("t3_blk_fire", 7);
        check("t3_blk_id", 32'(fire_id), 32'd1);
        arm(0, 0); arm(2, 0); arm(3, 0);
        tick(6);
        check("t3_all_pending", 32'(pending), 32'b1111);
        cancel(1);
        check("t3_cancel_drop", 32'(fire_valid), 32'd0);
        check("t3_cancel_pending", 32'(pending), 32'b1101);
        exp_q.push_back(2'd0); exp_q.push_back(2'd2); exp_q.push_back(2'd3);
        fire_ready = 1'b1;
        drain("t3_drain", 20);
        fire_ready = 1'b0;

        // After firing 3 the pointer wraps to 0: with 0 and 3 pending, 0 goes first.
        arm(1, 0);
        wait_fire("t3b_blk_fire", 7);
        check("t3b_blk_id", 32'(fire_id), 32'd1);
        arm(3, 0); arm(0, 0);
        tick(6);
        cancel(1);
        exp_q.push_back(2'd0); exp_q.push_back(2'd3);
        fire_ready = 1'b1;
        drain("t3b_drain", 20);
        fire_ready = 1'b0;

        // Cancel the channel currently on the fire port.
        arm(2, 0);
        wait_fire("t4_fire_valid", 7);
        check("t4_fire_id", 32'(fire_id), 32'd2);
        cancel(2);
        check("t4_fire_drop", 32'(fire_valid), 32'd0);
        check("t4_pending", 32'(pending), 32'd0);
        fire_ready = 1'b1;
        tick(8);
        check("t4_no_refire", 32'(fire_valid), 32'd0);
        fire_ready = 1'b0;

        // Arm and cancel of the same channel in one cycle.
        timer_count  = 16'd50;
        fire_ready   = 1'b1;
        arm_valid    = 1'b1; arm_id = 2'd3; arm_delay = 15'd10;
        cancel_valid = 1'b1; cancel_id = 2'd3;
        check("t5_arm_ready", 32'(arm_ready), 32'd1);
        tick(1);
        arm_valid = 1'b0; cancel_valid = 1'b0;
        check("t5_armed", 32'(armed), 32'd0);
        timer_count = 16'd60;
        tick(8);
        check("t5_no_fire", 32'(fire_valid), 32'd0);
        check("t5_pending", 32'(pending), 32'd0);
        fire_ready = 1'b0;

        // Randomised delay: no fire one tick early, fire exactly at the deadline.
        base = 16'($urandom_range(200, 60000));
        dly  = 16'($urandom_range(1, 30));
        timer_count = base;
        arm(2, int'(dly));
        timer_count = base + dly - 16'd1;
        tick(8);
        check("tr_no_early_fire", 32'(fire_valid), 32'd0);
        exp_q.push_back(2'd2);
        timer_count = base + dly;
        wait_fire("tr_fire_valid", 7);
        check("tr_fire_id", 32'(fire_id), 32'd2);
        fire_ready = 1'b1;
        drain("tr_drain", 4);
        fire_ready = 1'b0;

        // Timer clear disarms everything but keeps the pending fire.
        timer_count = 16'd60;
        arm(0, 1000); arm(1, 1000); arm(2, 0);
        tick(6);
        check("t6_armed", 32'(armed), 32'b0011);
        check("t6_pending", 32'(pending), 32'b0100);
        clear_timer = 1'b1;
        tick(1);
        clear_timer = 1'b0;
        check("t6_timer_reset_hi", 32'(timer_reset), 32'd1);
        check("t6_arm_ready_lo1", 32'(arm_ready), 32'd0);
        check("t6_armed_clr", 32'(armed), 32'd0);
        check("t6_pending_kept", 32'(pending), 32'b0100);
        tick(1);
        check("t6_timer_reset_lo", 32'(timer_reset), 32'd0);
        check("t6_arm_ready_lo2", 32'(arm_ready), 32'd0);
        tick(1);
        check("t6_arm_ready_hi", 32'(arm_ready), 32'd1);
        check("t6_timer_read", 32'(timer_read), 32'd1);
        exp_q.push_back(2'd2);
        fire_ready = 1'b1;
        drain("t6_drain", 10);
        tick(4);
        fire_ready = 1'b0;

        // Reset in the middle of a pending fire.
        arm(0, 0);
        wait_fire("t7_fire_valid", 7);
        reset = 1'b1;
        tick(1);
        check("t7_fire_valid", 32'(fire_valid), 32'd0);
        check("t7_armed", 32'(armed), 32'd0);
        check("t7_pending", 32'(pending), 32'd0);
        check("t7_timer_read", 32'(timer_read), 32'd0);
        check("t7_arm_ready", 32'(arm_ready), 32'd0);
        reset = 1'b0;
        tick(2);
        check("t7_run_again", 32'(arm_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
